// File: rtl/conv3x3_window_sink_if.sv
// Window, coefficient and result-stream signals shared by the generator, controller and reader.
interface conv3x3_window_sink_if;
    logic        win_valid;
    logic [71:0] win_data;
    logic        busy;
    logic        w_wr_en;
    logic [3:0]  w_wr_addr;
    logic [7:0]  w_wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        err;

    modport master (
        output win_valid, win_data, w_wr_en, w_wr_addr, w_wr_data, out_ready,
        input  busy, out_valid, out_data, out_last, err
    );
    modport slave (
        input  win_valid, win_data, w_wr_en, w_wr_addr, w_wr_data, out_ready,
        output busy, out_valid, out_data, out_last, err
    );
endinterface

// File: rtl/conv3x3_window_sink.sv
// 3x3 signed convolution over row-serial windows, requantised to u8 and buffered per frame,
// then drained as a stream while busy stalls the window generator.
module conv3x3_window_sink #(
    parameter int FRAME_LEN = 36,
    parameter int SHIFT     = 4,
    parameter int ACC_W     = 24
) (
    input logic                  clk,
    input logic                  rst_n,
    conv3x3_window_sink_if.slave bus
);
    localparam int PW = $clog2(FRAME_LEN);
    localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                   state, state_nxt;
    logic [1:0]               phase;
    logic signed [ACC_W-1:0]  acc, row_sum, bias_term, final_sum, q;
    logic signed [7:0]        weights [9];
    logic signed [7:0]        bias;
    logic [7:0]               res_mem [FRAME_LEN];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [7:0]               res;
    logic [23:0]              row_px;
    logic signed [7:0]        row_w [3];
    logic signed [16:0]       prod [3];
    logic                     win_fire, rd_fire, frame_done, drain_done;

    // The active row is chosen by phase; pixel 0 of the row sits in the top byte.
    always_comb begin
        row_px = bus.win_data[23:0];
        for (int c = 0; c < 3; c++) row_w[c] = weights[6 + c];
        case (phase)
            2'd0: begin
                row_px = bus.win_data[71:48];
                for (int c = 0; c < 3; c++) row_w[c] = weights[c];
            end
            2'd1: begin
                row_px = bus.win_data[47:24];
                for (int c = 0; c < 3; c++) row_w[c] = weights[3 + c];
            end
            default: ;
        endcase
    end

    generate
        for (genvar c = 0; c < 3; c++) begin : g_col
            logic [7:0] pix;
            assign pix     = row_px[23-8*c -: 8];
            assign prod[c] = 17'(signed'({1'b0, pix})) * 17'(row_w[c]);
        end
    endgenerate

    always_comb begin
        row_sum   = ACC_W'(prod[0]) + ACC_W'(prod[1]) + ACC_W'(prod[2]);
        bias_term = ACC_W'(bias) <<< SHIFT;
        final_sum = acc + row_sum + bias_term;
        q         = final_sum >>> SHIFT;
        if (q < 0)        res = 8'd0;
        else if (q > 255) res = 8'd255;
        else              res = q[7:0];
    end

    assign win_fire   = bus.win_valid && !bus.busy && (state == ACCUM);
    assign frame_done = win_fire && (phase == 2'd2) && (wr_ptr == LAST);
    assign rd_fire    = (state == DRAIN) && bus.out_ready;
    assign drain_done = rd_fire && (rd_ptr == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'd0;
        bus.out_last  = 1'b0;
        case (state)
            ACCUM: if (frame_done) state_nxt = DRAIN;
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_data  = res_mem[rd_ptr];
                bus.out_last  = (rd_ptr == LAST);
                if (drain_done) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy <= 1'b0;
            bus.err  <= 1'b0;
            phase    <= 2'd0;
            acc      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            bias     <= '0;
            for (int i = 0; i < 9; i++) weights[i] <= '0;
        end else begin
            bus.busy <= (state_nxt == DRAIN);
            // A window offered while stalled is dropped and flagged, never absorbed.
            if (bus.win_valid && bus.busy) bus.err <= 1'b1;
            if (bus.w_wr_en) begin
                if (bus.w_wr_addr < 4'd9)       weights[bus.w_wr_addr] <= bus.w_wr_data;
                else if (bus.w_wr_addr == 4'd9) bias <= bus.w_wr_data;
            end
            if (win_fire) begin
                phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                if (phase == 2'd0)      acc <= row_sum;
                else if (phase == 2'd1) acc <= acc + row_sum;
                if (phase == 2'd2)      wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_fire) rd_ptr <= drain_done ? '0 : rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (win_fire && phase == 2'd2) res_mem[wr_ptr] <= res;
    end
endmodule

// File: doc/conv3x3_window_sink.md
Name: conv3x3_window_sink

Overview:
Consumer end of the 3x3 window interface driven by the line-buffer/window generator. It accepts one 72-bit zero-padded window every three valid cycles. Each window is processed as one row per phase: a signed 3x3 convolution with bias, right-shift requantisation, ReLU and saturation to 8 bits. The 36 results of a 6x6 frame are buffered, and the block asserts busy to stall the window generator until a downstream stream reader has drained the frame.

Parameters:
FRAME_LEN, 36, results per frame (buffer depth); the last index is FRAME_LEN-1.
SHIFT, 4, arithmetic right shift applied to the accumulator before ReLU/saturation.
ACC_W, 24, accumulator width (signed).

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
win_valid  input  1  window phase valid (the generator's ready/can-do output)
win_data  input  72  window; pixel(r,c) = win_data[71-8*(3r+c) -: 8], unsigned, r,c in 0..2
busy  output  1  registered; high stalls the generator (drives its busy/fc input)
w_wr_en  input  1  coefficient write strobe
w_wr_addr  input  4  0..8 = weight(r,c) at index 3r+c; 9 = bias; 10..15 ignored
w_wr_data  input  8  signed coefficient
out_valid  output  1  result available
out_ready  input  1  downstream accept
out_data  output  8  unsigned result
out_last  output  1  high with out_valid on result FRAME_LEN-1
err  output  1  sticky protocol error

Behaviour:
- Reset values: busy=0, out_valid=0, out_data=0, out_last=0, err=0, phase=0, acc=0, wr_ptr=0, rd_ptr=0, weights=0, bias=0, state=ACCUM.
- Coefficient file:
  - A write takes effect at the next edge and is accepted in any state, with no interlock.
  - Changing coefficients mid-frame is the controller's responsibility.
- States: ACCUM, DRAIN.
- ACCUM:
  - phase (0..2) advances only on cycles with win_valid=1 and wraps 2->0. With win_valid=0, phase and acc hold, so mid-window stalls are lossless.
  - phase 0: acc <= sum over c of pixel(0,c)*w(0,c). This overwrites acc, with no carry from the previous window.
  - phase 1: acc <= acc + row-1 products.
  - phase 2: final = acc + row-2 products + (sign-extended bias << SHIFT).
  - Products are unsigned8 x signed8, computed as signed 17 bits and sign-extended to ACC_W.
- Requantisation of final:
  - q = final >>> SHIFT (arithmetic shift, truncation).
  - If q<0 then 0; if q>255 then 255; otherwise q[7:0].
  - The result is written to buf[wr_ptr] on the phase-2 edge, and wr_ptr increments.
- Frame completion:
  - On the phase-2 edge with wr_ptr==FRAME_LEN-1: wr_ptr<=0, state<=DRAIN, busy<=1.
  - busy is high from the cycle after the 36th window's phase 2.
- DRAIN:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==FRAME_LEN-1).
  - On out_valid&out_ready, rd_ptr increments.
  - out_data/out_valid are stable while out_ready=0.
  - On the accepted last beat: rd_ptr<=0, state<=ACCUM, busy<=0, out_valid<=0, effective the next cycle.
  - Minimum drain: 36 cycles with out_ready held at 1.
- Protocol error:
  - win_valid=1 while busy=1 sets err (sticky until reset).
  - The window is ignored: phase, acc and the buffer are unchanged.
- Outside DRAIN: out_valid=0 and out_last=0. out_data is don't-care; the implementation drives 0.
- Asynchronous reset at any point (mid-window, mid-drain) returns everything to reset values. Partial frames are discarded, and weights and bias are cleared.

Test Plan:
1. All weights=1, bias=0, SHIFT=0; 3 valid cycles of all-pixels=10 -> buf[0]=90; the 36th window completes -> busy=1 the next cycle, out_data=90 on the first beat.
2. SHIFT=4, weights=1, all pixels=255 -> final=2295, q=143; with SHIFT=0 -> saturates to 255; weight(1,1)=-1, others 0, centre=50 -> 0 (ReLU).
3. Bias=5, SHIFT=4, weights=0 -> final=80, q=5; weight(0,0)=-128, pixel(0,0)=255, bias=127, SHIFT=4 -> q<0 -> 0.
4. Stall: win_valid low for 5 cycles between phase 1 and phase 2 -> result identical to the unstalled case; phase holds at 2 throughout.
5. Full frame of 36 windows with results 0..35, then out_ready toggling 1,0,1,0 -> 36 beats in order; out_last only on value 35; busy falls the cycle after the last accept; a new frame then starts at wr_ptr=0.
6. win_valid pulsed during DRAIN -> err=1, buffer contents unchanged; rst_n asserted mid-drain -> busy=0, out_valid=0, err=0, weights=0.
